// File: rtl/i2c_poll_sequencer_if.sv
// Control and data bundle between the poll sequencer and the i2c_master.
// The sequencer drives the request side; the i2c_master answers with busy and read data.
interface i2c_poll_sequencer_if;
    logic        i2c_enable;
    logic        i2c_read_write;
    logic [15:0] i2c_register_address;
    logic [14:0] i2c_device_address;
    logic        i2c_busy;
    logic [15:0] i2c_miso_data;

    modport master (
        output i2c_enable,
        output i2c_read_write,
        output i2c_register_address,
        output i2c_device_address,
        input  i2c_busy,
        input  i2c_miso_data
    );

    modport slave (
        input  i2c_enable,
        input  i2c_read_write,
        input  i2c_register_address,
        input  i2c_device_address,
        output i2c_busy,
        output i2c_miso_data
    );
endinterface

// File: rtl/i2c_poll_sequencer.sv
// Periodic register poller for the 16-bit-register/16-bit-data i2c_master.
// Walks up to four register addresses on one device, one read at a time, and
// hands each result to the display logic as a one-cycle strobe. A watchdog
// aborts transactions that never complete, and RECOVER keeps a stuck-high busy
// from being mistaken for the acceptance of a new request.
module i2c_poll_sequencer #(
    parameter int          NUM_REGS    = 2,
    parameter logic [14:0] DEVICE_ADDR = 15'h0001,
    parameter logic [15:0] REG_ADDR0   = 16'h0000,
    parameter logic [15:0] REG_ADDR1   = 16'h0001,
    parameter logic [15:0] REG_ADDR2   = 16'h0002,
    parameter logic [15:0] REG_ADDR3   = 16'h0003,
    parameter int          INTERVAL    = 50000,
    parameter int          TIMEOUT     = 1000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    i2c_poll_sequencer_if.master i2c,
    output logic [15:0]          data,
    output logic [1:0]           data_idx,
    output logic                 data_valid,
    output logic                 timeout_err
);

    localparam int WAIT_W = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam int WDOG_W = $clog2(TIMEOUT);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(INTERVAL - 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);
    localparam logic [1:0]        LAST_SLOT = 2'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        XFER,
        WAIT,
        RECOVER
    } state_t;

    state_t            state,      state_n;
    logic [1:0]        slot,       slot_n;
    logic              enable_q,   enable_n;
    logic [15:0]       reg_addr_q, reg_addr_n;
    logic [15:0]       data_q,     data_n;
    logic [1:0]        idx_q,      idx_n;
    logic              valid_q,    valid_n;
    logic              terr_q,     terr_n;
    logic [WAIT_W-1:0] wait_cnt,   wait_n;
    logic [WDOG_W-1:0] wdog_cnt,   wdog_n;
    logic              begin_txn;

    // Register address for a slot of the fixed poll list.
    function automatic logic [15:0] reg_addr_of(input logic [1:0] s);
        case (s)
            2'd0:    return REG_ADDR0;
            2'd1:    return REG_ADDR1;
            2'd2:    return REG_ADDR2;
            default: return REG_ADDR3;
        endcase
    endfunction

    assign i2c.i2c_enable           = enable_q;
    assign i2c.i2c_read_write       = 1'b1;
    assign i2c.i2c_register_address = reg_addr_q;
    assign i2c.i2c_device_address   = DEVICE_ADDR;
    assign data                     = data_q;
    assign data_idx                 = idx_q;
    assign data_valid               = valid_q;
    assign timeout_err              = terr_q;

    // Next-state and next-output logic; every transaction start goes through begin_txn.
    always_comb begin
        state_n   = state;
        slot_n    = slot;
        enable_n  = enable_q;
        data_n    = data_q;
        idx_n     = idx_q;
        valid_n   = 1'b0;
        terr_n    = terr_q;
        wait_n    = wait_cnt;
        wdog_n    = wdog_cnt;
        begin_txn = 1'b0;

        case (state)
            IDLE: begin
                enable_n = 1'b0;
                slot_n   = 2'd0;
                if (run) begin
                    begin_txn = 1'b1;
                end
            end

            START, XFER: begin
                if (wdog_cnt == WDOG_LAST) begin
                    terr_n   = 1'b1;
                    enable_n = 1'b0;
                    slot_n   = 2'd0;
                    state_n  = RECOVER;
                end else begin
                    wdog_n = wdog_cnt + 1'b1;
                    if (state == START) begin
                        if (i2c.i2c_busy) begin
                            state_n  = XFER;
                            enable_n = 1'b0;
                        end
                    end else if (!i2c.i2c_busy) begin
                        enable_n = 1'b0;
                        data_n   = i2c.i2c_miso_data;
                        idx_n    = slot;
                        valid_n  = 1'b1;
                        if (!run) begin
                            state_n = IDLE;
                            slot_n  = 2'd0;
                        end else if (slot < LAST_SLOT) begin
                            slot_n    = slot + 2'd1;
                            begin_txn = 1'b1;
                        end else begin
                            slot_n  = 2'd0;
                            state_n = WAIT;
                            wait_n  = '0;
                        end
                    end
                end
            end

            WAIT: begin
                enable_n = 1'b0;
                if (!run) begin
                    state_n = IDLE;
                    slot_n  = 2'd0;
                end else if (wait_cnt == WAIT_LAST) begin
                    slot_n    = 2'd0;
                    begin_txn = 1'b1;
                end else begin
                    wait_n = wait_cnt + 1'b1;
                end
            end

            RECOVER: begin
                enable_n = 1'b0;
                if (!i2c.i2c_busy) begin
                    if (run) begin
                        state_n = WAIT;
                        wait_n  = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end

            default: begin
                state_n  = IDLE;
                enable_n = 1'b0;
                slot_n   = 2'd0;
            end
        endcase

        if (begin_txn) begin
            state_n  = START;
            enable_n = 1'b1;
            wdog_n   = '0;
        end

        reg_addr_n = reg_addr_of(slot_n);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            slot       <= 2'd0;
            enable_q   <= 1'b0;
            reg_addr_q <= REG_ADDR0;
            data_q     <= 16'h0000;
            idx_q      <= 2'd0;
            valid_q    <= 1'b0;
            terr_q     <= 1'b0;
            wait_cnt   <= '0;
            wdog_cnt   <= '0;
        end else begin
            state      <= state_n;
            slot       <= slot_n;
            enable_q   <= enable_n;
            reg_addr_q <= reg_addr_n;
            data_q     <= data_n;
            idx_q      <= idx_n;
            valid_q    <= valid_n;
            terr_q     <= terr_n;
            wait_cnt   <= wait_n;
            wdog_cnt   <= wdog_n;
        end
    end

endmodule

// File: tb/tb_i2c_poll_sequencer.sv
// Self-checking bench for i2c_poll_sequencer: behavioural i2c_master responder,
// directed sequences, and a scoreboard that checks every data_valid strobe.
module tb_i2c_poll_sequencer;

    localparam int BFM_NORMAL = 0;
    localparam int BFM_NEVER  = 1;
    localparam int BFM_STUCK  = 2;

    localparam int CNT_PULSES = 0;
    localparam int CNT_FALLS  = 1;
    localparam int CNT_DV     = 2;

    typedef struct {
        logic [15:0] d;
        logic [1:0]  idx;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic [15:0] data;
    logic [1:0]  data_idx;
    logic        data_valid;
    logic        timeout_err;

    i2c_poll_sequencer_if bus ();

    i2c_poll_sequencer #(
        .NUM_REGS    (2),
        .DEVICE_ADDR (15'h0001),
        .REG_ADDR0   (16'h0000),
        .REG_ADDR1   (16'h0001),
        .REG_ADDR2   (16'h0002),
        .REG_ADDR3   (16'h0003),
        .INTERVAL    (10),
        .TIMEOUT     (50)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .i2c         (bus),
        .data        (data),
        .data_idx    (data_idx),
        .data_valid  (data_valid),
        .timeout_err (timeout_err)
    );

    int checks = 0;
    int errors = 0;

    int bfm_mode  = BFM_NORMAL;
    int bfm_delay = 2;
    int bfm_hold  = 20;
    logic [15:0] bfm_mem [4];

    exp_t        sb_q [$];
    logic [15:0] addr_log [$];
    int  cyc         = 0;
    logic en_prev    = 1'b0;
    int  en_pulses   = 0;
    int  en_falls    = 0;
    int  en_len      = 0;
    int  last_en_len = 0;
    int  en_rise_cyc = 0;
    int  en_fall_cyc = 0;
    int  dv_count    = 0;
    int  last_dv_cyc = 0;

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic apply_stimulus(input logic r);
        run = r;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic push_expected(input logic [15:0] d, input logic [1:0] idx);
        exp_t e;
        e.d   = d;
        e.idx = idx;
        sb_q.push_back(e);
    endtask

    function automatic int count_of(input int which);
        case (which)
            CNT_PULSES: return en_pulses;
            CNT_FALLS:  return en_falls;
            default:    return dv_count;
        endcase
    endfunction

    function automatic logic [31:0] log_at(input int i);
        if (i < addr_log.size()) return 32'(addr_log[i]);
        return 32'hFFFF_FFFF;
    endfunction

    task automatic wait_count(input string name, input int which, input int target, input int budget);
        int n;
        n = 0;
        while (count_of(which) < target && n < budget) begin
            tick(1);
            n++;
        end
        if (count_of(which) < target) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: actual count %0d after %0d cycles, required %0d", name, count_of(which), budget, target);
        end
    endtask

    // Behavioural i2c_master: raises busy once enable has been high bfm_delay cycles, then returns bfm_mem data.
    initial begin
        int         en_cnt;
        int         hold_cnt;
        bit         active;
        logic [1:0] addr;
        en_cnt   = 0;
        hold_cnt = 0;
        active   = 1'b0;
        addr     = 2'd0;
        bus.i2c_busy      = 1'b0;
        bus.i2c_miso_data = 16'h0000;
        forever begin
            @(negedge clk);
            if (reset) begin
                bus.i2c_busy = 1'b0;
                active       = 1'b0;
                en_cnt       = 0;
            end else if (!active) begin
                if (bus.i2c_enable) begin
                    en_cnt++;
                    if (bfm_mode != BFM_NEVER && en_cnt >= bfm_delay) begin
                        bus.i2c_busy = 1'b1;
                        active       = 1'b1;
                        hold_cnt     = 0;
                        en_cnt       = 0;
                        addr         = bus.i2c_register_address[1:0];
                    end
                end else begin
                    en_cnt = 0;
                end
            end else if (bfm_mode != BFM_STUCK) begin
                hold_cnt++;
                if (hold_cnt >= bfm_hold) begin
                    bus.i2c_busy      = 1'b0;
                    bus.i2c_miso_data = bfm_mem[addr];
                    active            = 1'b0;
                end
            end
        end
    end

    // Monitor: scoreboard pop on every data_valid, plus enable pulse timing and address log.
    initial begin
        exp_t item;
        forever begin
            @(negedge clk);
            cyc++;
            if (data_valid) begin
                dv_count++;
                last_dv_cyc = cyc;
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL sb_unexpected_capture: actual data=0x%0h idx=%0d, required no capture", data, data_idx);
                end else begin
                    item = sb_q.pop_front();
                    check_output("sb_data", 32'(data), 32'(item.d));
                    check_output("sb_idx", 32'(data_idx), 32'(item.idx));
                end
            end
            if (bus.i2c_enable && !en_prev) begin
                en_pulses++;
                en_rise_cyc = cyc;
                en_len      = 1;
                addr_log.push_back(bus.i2c_register_address);
            end else if (bus.i2c_enable) begin
                en_len++;
            end else if (en_prev) begin
                en_falls++;
                en_fall_cyc = cyc;
                last_en_len = en_len;
            end
            en_prev = bus.i2c_enable;
        end
    end

    // Hard stop in case a sequence wedges outside the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "[TB] aborted");
    end

    // Directed sequences.
    initial begin
        int base_p;
        int base_f;
        int base_dv;

        bfm_mem[0] = 16'hA5A5;
        bfm_mem[1] = 16'h1234;
        bfm_mem[2] = 16'h0F0F;
        bfm_mem[3] = 16'hBEEF;

        $display("[TB] reset values");
        reset = 1'b1;
        apply_stimulus(1'b0);
        tick(3);
        check_output("rst_enable", 32'(bus.i2c_enable), 32'd0);
        check_output("rst_read_write", 32'(bus.i2c_read_write), 32'd1);
        check_output("rst_reg_addr", 32'(bus.i2c_register_address), 32'h0000);
        check_output("rst_dev_addr", 32'(bus.i2c_device_address), 32'h0001);
        check_output("rst_data", 32'(data), 32'h0000);
        check_output("rst_data_idx", 32'(data_idx), 32'd0);
        check_output("rst_data_valid", 32'(data_valid), 32'd0);
        check_output("rst_timeout_err", 32'(timeout_err), 32'd0);
        reset = 1'b0;
        tick(1);

        $display("[TB] two-slot round and interval");
        bfm_mode  = BFM_NORMAL;
        bfm_delay = 2;
        bfm_hold  = 20;
        base_p  = en_pulses;
        base_dv = dv_count;
        push_expected(16'hA5A5, 2'd0);
        push_expected(16'h1234, 2'd1);
        apply_stimulus(1'b1);
        wait_count("t1_captures", CNT_DV, base_dv + 2, 200);
        wait_count("t1_restart", CNT_PULSES, base_p + 3, 100);
        apply_stimulus(1'b0);
        push_expected(16'hA5A5, 2'd0);
        check_output("t1_addr_slot0", log_at(base_p), 32'h0000);
        check_output("t1_addr_slot1", log_at(base_p + 1), 32'h0001);
        check_output("t1_addr_round2", log_at(base_p + 2), 32'h0000);
        check_output("t1_interval", 32'(en_rise_cyc - last_dv_cyc), 32'd10);
        check_output("t1_enable_len", 32'(last_en_len), 32'd2);
        wait_count("t1_drain", CNT_DV, base_dv + 3, 200);
        tick(20);
        check_output("t1_no_extra_start", 32'(en_pulses), 32'(base_p + 3));

        $display("[TB] enable pulse length and run drop in XFER");
        apply_reset();
        bfm_delay = 3;
        bfm_hold  = 8;
        base_p  = en_pulses;
        base_f  = en_falls;
        base_dv = dv_count;
        push_expected(16'hA5A5, 2'd0);
        apply_stimulus(1'b1);
        wait_count("t2_accept", CNT_FALLS, base_f + 1, 50);
        apply_stimulus(1'b0);
        check_output("t2_enable_len", 32'(last_en_len), 32'd3);
        wait_count("t3_capture", CNT_DV, base_dv + 1, 100);
        tick(40);
        check_output("t3_no_slot1_start", 32'(en_pulses), 32'(base_p + 1));

        $display("[TB] watchdog with no response");
        apply_reset();
        bfm_mode = BFM_NEVER;
        base_p  = en_pulses;
        base_f  = en_falls;
        base_dv = dv_count;
        apply_stimulus(1'b1);
        wait_count("t4_abort", CNT_FALLS, base_f + 1, 100);
        check_output("t4_enable_len", 32'(last_en_len), 32'd50);
        check_output("t4_timeout_err", 32'(timeout_err), 32'd1);
        wait_count("t4_retry", CNT_PULSES, base_p + 2, 50);
        check_output("t4_retry_gap", 32'(en_rise_cyc - en_fall_cyc), 32'd11);
        check_output("t4_retry_addr", log_at(base_p + 1), 32'h0000);
        apply_stimulus(1'b0);
        wait_count("t4_second_abort", CNT_FALLS, base_f + 2, 100);
        tick(5);
        check_output("t4_no_capture", 32'(dv_count), 32'(base_dv));
        check_output("t4_sticky", 32'(timeout_err), 32'd1);

        $display("[TB] stuck busy and recover");
        bfm_mode  = BFM_STUCK;
        bfm_delay = 2;
        bfm_hold  = 20;
        base_p  = en_pulses;
        base_f  = en_falls;
        base_dv = dv_count;
        apply_stimulus(1'b1);
        wait_count("t5_accept", CNT_FALLS, base_f + 1, 50);
        check_output("t5_enable_len", 32'(last_en_len), 32'd2);
        tick(80);
        check_output("t5_recover_no_start", 32'(en_pulses), 32'(base_p + 1));
        check_output("t5_recover_enable", 32'(bus.i2c_enable), 32'd0);
        check_output("t5_no_false_capture", 32'(dv_count), 32'(base_dv));
        check_output("t5_sticky", 32'(timeout_err), 32'd1);
        push_expected(16'hA5A5, 2'd0);
        bfm_hold = 1;
        bfm_mode = BFM_NORMAL;
        tick(1);
        bfm_hold = 20;
        wait_count("t5_retry", CNT_PULSES, base_p + 2, 50);
        check_output("t5_retry_addr", log_at(base_p + 1), 32'h0000);
        wait_count("t5_capture", CNT_DV, base_dv + 1, 100);

        $display("[TB] reset during XFER");
        wait_count("t6_slot1_start", CNT_PULSES, base_p + 3, 50);
        check_output("t6_slot1_addr", log_at(base_p + 2), 32'h0001);
        tick(5);
        reset = 1'b1;
        tick(1);
        check_output("t6_enable", 32'(bus.i2c_enable), 32'd0);
        check_output("t6_read_write", 32'(bus.i2c_read_write), 32'd1);
        check_output("t6_reg_addr", 32'(bus.i2c_register_address), 32'h0000);
        check_output("t6_dev_addr", 32'(bus.i2c_device_address), 32'h0001);
        check_output("t6_data", 32'(data), 32'h0000);
        check_output("t6_data_idx", 32'(data_idx), 32'd0);
        check_output("t6_data_valid", 32'(data_valid), 32'd0);
        check_output("t6_timeout_err", 32'(timeout_err), 32'd0);
        tick(1);
        reset = 1'b0;
        base_p  = en_pulses;
        base_dv = dv_count;
        push_expected(16'hA5A5, 2'd0);
        wait_count("t6_restart", CNT_PULSES, base_p + 1, 20);
        check_output("t6_restart_addr", log_at(base_p), 32'h0000);
        apply_stimulus(1'b0);
        wait_count("t6_capture", CNT_DV, base_dv + 1, 100);
        tick(10);
        check_output("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
